// File: rtl/ifu_fetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
// Covers the fetch FSM state encoding, the buffered {addr, inst} entry and the bubble instruction.
package ifu_fetch_pkg;

    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_GNT    = 2'd1,
        WAIT_RVALID = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Small synchronous fetch buffer with push/pop/flush and an occupancy count.
// Flush wins over push and pop; pop on empty and push on full are ignored.
module ifu_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic [WIDTH-1:0]             head_data,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty     = (count == '0);
    assign do_push   = push && (count != CNT_W'(DEPTH));
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            if (do_push && !do_pop)
                count <= count + CNT_W'(1);
            else if (do_pop && !do_push)
                count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst && !flush && do_push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch: PC generation, single-outstanding ibus request FSM, kill on redirect,
// and the fetch buffer that feeds {inst, addr} to the IF/ID register.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_flag_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    fetch_state_t     state;
    logic [31:0]      pc;
    logic [31:0]      req_addr;
    logic             kill;

    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic [63:0]      head_raw;
    fetch_entry_t     head;
    fetch_entry_t     push_entry;
    logic             has_space;
    logic             issue;
    logic             push;
    logic             pop;

    // Nothing is outstanding while IDLE, so occupancy alone decides whether a slot is free.
    assign has_space   = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign issue       = rst && (state == IDLE) && !jump_en_i && has_space;
    assign ibus_req_o  = issue || (rst && (state == WAIT_GNT));
    assign ibus_addr_o = (state == WAIT_GNT) ? req_addr : pc;

    assign push_entry  = '{addr: req_addr, inst: ibus_rdata_i};
    assign push        = (state == WAIT_RVALID) && ibus_rvalid_i && !kill && !jump_en_i;
    assign pop         = inst_valid_o && !hold_flag_i && !jump_en_i;

    assign head         = fetch_entry_t'(head_raw);
    assign inst_valid_o = !fifo_empty;
    assign inst_o       = fifo_empty ? INST_NOP : head.inst;
    assign inst_addr_o  = fifo_empty ? 32'h0    : head.addr;

    ifu_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (jump_en_i),
        .head_data (head_raw),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            kill     <= 1'b0;
        end else begin
            if (jump_en_i)
                pc <= word_align(jump_addr_i);
            case (state)
                IDLE: begin
                    if (issue) begin
                        req_addr <= pc;
                        if (ibus_gnt_i) begin
                            pc    <= pc + 32'd4;
                            state <= WAIT_RVALID;
                        end else begin
                            state <= WAIT_GNT;
                        end
                    end
                end
                WAIT_GNT: begin
                    // A redirect cannot withdraw the request; it is finished and its data discarded.
                    if (jump_en_i)
                        kill <= 1'b1;
                    if (ibus_gnt_i) begin
                        state <= WAIT_RVALID;
                        if (!kill && !jump_en_i)
                            pc <= req_addr + 32'd4;
                    end
                end
                WAIT_RVALID: begin
                    if (ibus_rvalid_i) begin
                        state <= IDLE;
                        kill  <= 1'b0;
                    end else if (jump_en_i) begin
                        kill <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
